// File: rtl/gpu_cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpu_cmd_pkg: opcodes, sequencer states and command-entry sizing for the blitter queue.
// Rev 1.0
// ----------------------------------------------------------------------------
package gpu_cmd_pkg;

  localparam logic [1:0] OP_DRAW  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_FENCE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FENCE = 2'd3
  } seq_state_t;

  // op + address + address_x/address_y/image_width/clear_color + width/x + height/y
  function automatic int cmd_entry_width(input int wx, input int wy);
    return 2 + 32 + 4 * 16 + 2 * wx + 2 * wy;
  endfunction

  localparam int CMD_ENTRY_W = cmd_entry_width(11, 10);

endpackage
`default_nettype wire

// File: rtl/gpu_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpu_cmd_fifo: single-clock FIFO with registered count; head is read from storage only.
// Rev 1.0
// ----------------------------------------------------------------------------
module gpu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gpu_cmd_sequencer: queues blitter commands and issues them one at a time to the GPU.
// Define GPU_CMD_FENCE_EN to add frame_sync and the FENCE opcode. Rev 1.0
// ----------------------------------------------------------------------------
module gpu_cmd_sequencer
  import gpu_cmd_pkg::*;
#(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int DEPTH     = 8,
  localparam int WX = $clog2(FB_WIDTH) + 2,
  localparam int WY = $clog2(FB_HEIGHT) + 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [31:0]   cmd_address,
  input  logic [15:0]   cmd_address_x,
  input  logic [15:0]   cmd_address_y,
  input  logic [15:0]   cmd_image_width,
  input  logic [WX-1:0] cmd_width,
  input  logic [WY-1:0] cmd_height,
  input  logic [WX-1:0] cmd_x,
  input  logic [WY-1:0] cmd_y,
  input  logic [15:0]   cmd_clear_color,
  input  logic          gpu_busy,
`ifdef GPU_CMD_FENCE_EN
  input  logic          frame_sync,
`endif
  output logic [31:0]   ctrl_address,
  output logic [15:0]   ctrl_address_x,
  output logic [15:0]   ctrl_address_y,
  output logic [15:0]   ctrl_image_width,
  output logic [WX-1:0] ctrl_width,
  output logic [WY-1:0] ctrl_height,
  output logic [WX-1:0] ctrl_x,
  output logic [WY-1:0] ctrl_y,
  output logic [15:0]   ctrl_clear_color,
  output logic          ctrl_draw,
  output logic          ctrl_clear,
  output logic [CW-1:0] q_count,
  output logic          idle,
  output logic          err_op
);

  localparam int EW = cmd_entry_width(WX, WY);

  logic [EW-1:0] entry_in;
  logic [EW-1:0] entry_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          load;
  logic          draw_nx;
  logic          clear_nx;
  logic          err_nx;
  seq_state_t    state;
  seq_state_t    state_nx;

  logic [1:0]    h_op;
  logic [31:0]   h_address;
  logic [15:0]   h_address_x;
  logic [15:0]   h_address_y;
  logic [15:0]   h_image_width;
  logic [WX-1:0] h_width;
  logic [WY-1:0] h_height;
  logic [WX-1:0] h_x;
  logic [WY-1:0] h_y;
  logic [15:0]   h_clear_color;

  assign entry_in = {cmd_op, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
                     cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color};
  assign {h_op, h_address, h_address_x, h_address_y, h_image_width,
          h_width, h_height, h_x, h_y, h_clear_color} = entry_head;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign idle      = fifo_empty && (state == S_IDLE) && !gpu_busy;

  gpu_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry_in),
    .pop   (pop),
    .rdata (entry_head),
    .count (q_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    draw_nx  = 1'b0;
    clear_nx = 1'b0;
    err_nx   = err_op;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !gpu_busy) begin
          pop = 1'b1;
          case (h_op)
            OP_DRAW: begin
              load     = 1'b1;
              draw_nx  = 1'b1;
              state_nx = S_ISSUE;
            end
            OP_CLEAR: begin
              load     = 1'b1;
              clear_nx = 1'b1;
              state_nx = S_ISSUE;
            end
`ifdef GPU_CMD_FENCE_EN
            OP_FENCE: state_nx = S_FENCE;
`endif
            default: err_nx = 1'b1;
          endcase
        end
      end
      // Strobe register is already high during this cycle; it drops on exit.
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (!gpu_busy) state_nx = S_IDLE;
`ifdef GPU_CMD_FENCE_EN
      S_FENCE: if (frame_sync) state_nx = S_IDLE;
`else
      S_FENCE: state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_address     <= '0;
      ctrl_address_x   <= '0;
      ctrl_address_y   <= '0;
      ctrl_image_width <= '0;
      ctrl_width       <= '0;
      ctrl_height      <= '0;
      ctrl_x           <= '0;
      ctrl_y           <= '0;
      ctrl_clear_color <= '0;
      ctrl_draw        <= 1'b0;
      ctrl_clear       <= 1'b0;
      err_op           <= 1'b0;
    end else begin
      ctrl_draw  <= draw_nx;
      ctrl_clear <= clear_nx;
      err_op     <= err_nx;
      if (load) begin
        ctrl_address     <= h_address;
        ctrl_address_x   <= h_address_x;
        ctrl_address_y   <= h_address_y;
        ctrl_image_width <= h_image_width;
        ctrl_width       <= h_width;
        ctrl_height      <= h_height;
        ctrl_x           <= h_x;
        ctrl_y           <= h_y;
        ctrl_clear_color <= h_clear_color;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gpu_cmd_sequencer: directed bench with a simple busy-counter GPU model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gpu_cmd_sequencer;

  localparam int WX = 11;
  localparam int WY = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [31:0]   cmd_address = '0;
  logic [15:0]   cmd_address_x = '0;
  logic [15:0]   cmd_address_y = '0;
  logic [15:0]   cmd_image_width = '0;
  logic [WX-1:0] cmd_width = '0;
  logic [WY-1:0] cmd_height = '0;
  logic [WX-1:0] cmd_x = '0;
  logic [WY-1:0] cmd_y = '0;
  logic [15:0]   cmd_clear_color = '0;
  logic          gpu_busy;
`ifdef GPU_CMD_FENCE_EN
  logic          frame_sync = 1'b0;
`endif
  logic [31:0]   ctrl_address;
  logic [15:0]   ctrl_address_x;
  logic [15:0]   ctrl_address_y;
  logic [15:0]   ctrl_image_width;
  logic [WX-1:0] ctrl_width;
  logic [WY-1:0] ctrl_height;
  logic [WX-1:0] ctrl_x;
  logic [WY-1:0] ctrl_y;
  logic [15:0]   ctrl_clear_color;
  logic          ctrl_draw;
  logic          ctrl_clear;
  logic [3:0]    q_count;
  logic          idle;
  logic          err_op;

  logic          ext_busy = 1'b0;
  int            busy_len = 8;
  int            busy_cnt = 0;
  logic [WX-1:0] draw_log[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // GPU model: busy for busy_len cycles after each strobe; another master may hold it too.
  assign gpu_busy = ext_busy || (busy_cnt != 0);
  always @(posedge clk) begin
    if (reset)                        busy_cnt <= 0;
    else if (ctrl_draw || ctrl_clear) busy_cnt <= busy_len;
    else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    if (ctrl_draw) draw_log.push_back(ctrl_width);
  end

  gpu_cmd_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_address      (cmd_address),
    .cmd_address_x    (cmd_address_x),
    .cmd_address_y    (cmd_address_y),
    .cmd_image_width  (cmd_image_width),
    .cmd_width        (cmd_width),
    .cmd_height       (cmd_height),
    .cmd_x            (cmd_x),
    .cmd_y            (cmd_y),
    .cmd_clear_color  (cmd_clear_color),
    .gpu_busy         (gpu_busy),
`ifdef GPU_CMD_FENCE_EN
    .frame_sync       (frame_sync),
`endif
    .ctrl_address     (ctrl_address),
    .ctrl_address_x   (ctrl_address_x),
    .ctrl_address_y   (ctrl_address_y),
    .ctrl_image_width (ctrl_image_width),
    .ctrl_width       (ctrl_width),
    .ctrl_height      (ctrl_height),
    .ctrl_x           (ctrl_x),
    .ctrl_y           (ctrl_y),
    .ctrl_clear_color (ctrl_clear_color),
    .ctrl_draw        (ctrl_draw),
    .ctrl_clear       (ctrl_clear),
    .q_count          (q_count),
    .idle             (idle),
    .err_op           (err_op)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push_cmd(input logic [1:0] op, input logic [WX-1:0] w, input logic [WY-1:0] h,
                          input logic [WX-1:0] x, input logic [WY-1:0] y,
                          input logic [15:0] color, input logic [31:0] addr);
    cmd_op = op; cmd_width = w; cmd_height = h; cmd_x = x; cmd_y = y;
    cmd_clear_color = color; cmd_address = addr; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && !idle; i++) tick();
    check(tag, idle, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_at, drw_at, busy_last, found;
    logic unstable, back2back, prev, accepted, strobe_seen;
    logic [15:0] col;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_q_count", q_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_strobes", {ctrl_draw, ctrl_clear}, 0);
    check("rst_ctrl_width", ctrl_width, 0);
    check("rst_err_op", err_op, 0);

    // Single DRAW
    busy_len = 8;
    push_cmd(2'd0, 11'd4, 10'd2, 11'd10, 10'd20, 16'h0, 32'h1000);
    check("t1_queued", q_count, 1);
    check("t1_no_early_strobe", ctrl_draw, 0);
    tick();
    check("t1_strobe", ctrl_draw, 1);
    check("t1_fields", {ctrl_width, ctrl_height, ctrl_x, ctrl_y}, {11'd4, 10'd2, 11'd10, 10'd20});
    check("t1_popped", q_count, 0);
    tick();
    check("t1_strobe_1cyc", ctrl_draw, 0);
    unstable = 1'b0;
    for (int i = 0; i < 30 && gpu_busy; i++) begin
      if (ctrl_width != 11'd4 || ctrl_draw) unstable = 1'b1;
      tick();
    end
    check("t1_stable", unstable, 0);
    wait_idle("t1_idle");

    // CLEAR then DRAW back to back; second push coincides with the first pop
    busy_len = 4;
    push_cmd(2'd1, 11'd0, 10'd0, 11'd0, 10'd0, 16'hF801, 32'h2000);
    push_cmd(2'd0, 11'd8, 10'd8, 11'd1, 10'd1, 16'h0, 32'h3000);
    check("t2_pushpop_count", q_count, 1);
    clr_at = -1; drw_at = -1; busy_last = -1; back2back = 1'b0; prev = 1'b0; col = '0;
    for (int i = 0; i < 40; i++) begin
      if (ctrl_clear && clr_at < 0) begin clr_at = i; col = ctrl_clear_color; end
      if (ctrl_draw && drw_at < 0) drw_at = i;
      if (gpu_busy && drw_at < 0) busy_last = i;
      if ((ctrl_draw || ctrl_clear) && prev) back2back = 1'b1;
      prev = ctrl_draw || ctrl_clear;
      tick();
    end
    check("t2_clear_at", clr_at, 0);
    check("t2_draw_seen", drw_at >= 0, 1);
    check("t2_gap_ge3", (drw_at - clr_at) >= 3, 1);
    check("t2_color", col, 16'hF801);
    check("t2_after_busy", busy_last < drw_at, 1);
    check("t2_no_back2back", back2back, 0);
    wait_idle("t2_idle");

    // Fill the queue while the GPU is held busy
    busy_len = 1;
    ext_busy = 1'b1;
    draw_log.delete();
    for (int k = 0; k < 8; k++) push_cmd(2'd0, 11'(k + 1), 10'd1, 11'd0, 10'd0, 16'h0, 32'h0);
    check("t3_full_count", q_count, 8);
    check("t3_full_ready", cmd_ready, 0);
    cmd_op = 2'd0; cmd_width = 11'd9; cmd_valid = 1'b1;
    tick();
    check("t3_blocked", q_count, 8);
    ext_busy = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (cmd_ready) accepted = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_ninth_accepted", accepted, 1);
    check("t3_refilled", q_count, 8);
    for (int i = 0; i < 300 && draw_log.size() < 9; i++) tick();
    tick();
    check("t3_draw_count", draw_log.size(), 9);
    for (int k = 0; k < 9 && k < draw_log.size(); k++) check("t3_order", draw_log[k], 11'(k + 1));
    wait_idle("t3_idle");

    // External master holds the GPU busy
    ext_busy = 1'b1;
    push_cmd(2'd1, 11'd0, 10'd0, 11'd0, 10'd0, 16'h1234, 32'h0);
    strobe_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ctrl_draw || ctrl_clear) strobe_seen = 1'b1;
      tick();
    end
    check("t4_no_strobe", strobe_seen, 0);
    check("t4_no_pop", q_count, 1);
    ext_busy = 1'b0;
    found = 0;
    for (int i = 0; i < 2 && found == 0; i++) begin
      tick();
      if (ctrl_clear) found = 1;
    end
    check("t4_strobe_2cyc", found, 1);
    check("t4_color", ctrl_clear_color, 16'h1234);
    wait_idle("t4_idle");

    // Reset during a long draw with entries queued
    busy_len = 20;
    push_cmd(2'd0, 11'd7, 10'd3, 11'd5, 10'd6, 16'h0, 32'hDEAD_BEEF);
    for (int i = 0; i < 5 && !ctrl_draw; i++) tick();
    check("t5_strobe", ctrl_draw, 1);
    for (int k = 0; k < 3; k++) push_cmd(2'd0, 11'd1, 10'd1, 11'd1, 10'd1, 16'h0, 32'h0);
    check("t5_queued", q_count, 3);
    check("t5_held_addr", ctrl_address, 32'hDEAD_BEEF);
    reset = 1'b1;
    tick();
    check("t5_flushed", q_count, 0);
    check("t5_strobes", {ctrl_draw, ctrl_clear}, 0);
    check("t5_ctrl_zero", {ctrl_address, ctrl_width, ctrl_height}, 0);
    check("t5_ready", cmd_ready, 1);
    reset = 1'b0;
    tick();
    check("t5_idle", idle, 1);

`ifdef GPU_CMD_FENCE_EN
    busy_len = 2;
    push_cmd(2'd2, 11'd0, 10'd0, 11'd0, 10'd0, 16'h0, 32'h0);
    push_cmd(2'd0, 11'd5, 10'd5, 11'd0, 10'd0, 16'h0, 32'h0);
    drw_at = -1;
    for (int t = 0; t < 80; t++) begin
      frame_sync = (t == 50);
      if (ctrl_draw && drw_at < 0) drw_at = t;
      tick();
    end
    frame_sync = 1'b0;
    check("fence_draw_seen", drw_at >= 0, 1);
    check("fence_draw_after_sync", drw_at >= 51, 1);
    check("fence_no_err", err_op, 0);
`else
    push_cmd(2'd2, 11'd13, 10'd1, 11'd0, 10'd0, 16'h0, 32'h0);
    check("t6_err_before_pop", err_op, 0);
    tick();
    check("t6_err_set", err_op, 1);
    check("t6_popped", q_count, 0);
    check("t6_ctrl_unchanged", ctrl_width, 0);
    check("t6_no_strobe", {ctrl_draw, ctrl_clear}, 0);
    push_cmd(2'd3, 11'd14, 10'd1, 11'd0, 10'd0, 16'h0, 32'h0);
    tick();
    check("t6_err_sticky", err_op, 1);
    check("t6_idle", idle, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
